// File: rtl/bitmap_vram_pkg.sv
// Shared types and the pixel-lane helper for the time-sliced bitmap VRAM.
package bitmap_vram_pkg;

  localparam int unsigned LANE_W = 64;

  typedef logic [LANE_W-1:0] lane_t;

  typedef enum logic [1:0] {
    OP_BYTE_RD = 2'd0,
    OP_BYTE_WR = 2'd1,
    OP_PIX_RD  = 2'd2,
    OP_PIX_WR  = 2'd3
  } host_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RMW_READ,
    ST_RMW_WRITE,
    ST_WAIT_ACK
  } host_state_e;

  // Pixel idx sits at bits [(ppw-1-idx)*bpp +: bpp]; merge=0 extracts it, merge=1 replaces it with val.
  function automatic lane_t pix_lane(input lane_t word, input int unsigned idx,
                                     input int unsigned bpp, input int unsigned ppw,
                                     input logic merge, input lane_t val);
    lane_t       mask;
    int unsigned sh;
    sh   = (ppw - 1 - idx) * bpp;
    mask = (lane_t'(1) << bpp) - lane_t'(1);
    if (merge) pix_lane = (word & ~(mask << sh)) | ((val & mask) << sh);
    else       pix_lane = (word >> sh) & mask;
  endfunction

endpackage

// File: rtl/vram_sp.sv
// Single-port synchronous RAM, one-cycle read latency, write-first.
module vram_sp #(
  parameter int unsigned ADDR_W = 15,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/bitmap_vram_arbiter.sv
// Bitmap VRAM shared between a host port (byte/pixel ops, RMW pixel writes)
// and video scanout, alternating host and video slots every clock.
module bitmap_vram_arbiter
  import bitmap_vram_pkg::*;
#(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned BPP        = 4,
  parameter int unsigned PROT_LIMIT = 4096,
  localparam int unsigned PPW       = DATA_W / BPP,
  localparam int unsigned PIX_W     = (PPW > 1) ? $clog2(PPW) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_req,
  input  logic [1:0]        host_op,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [PIX_W-1:0]  host_pix,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic [PIX_W-1:0]  vid_pix,
  output logic [BPP-1:0]    vid_pixel,
  output logic              vid_valid,
  output logic              slot_phase
);

  host_state_e       state;
  host_op_e          op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  pix_q;
  logic [BPP-1:0]    pval_q;
  logic [DATA_W-1:0] old_q;
  logic [PIX_W-1:0]  vpix_q;
  logic              vid_rd_q;

  logic              accept_c;
  logic              prot_c;
  logic              ram_we_c;
  logic [ADDR_W-1:0] ram_addr_c;
  logic [DATA_W-1:0] ram_wdata_c;
  logic [DATA_W-1:0] merged_c;
  logic [BPP-1:0]    host_pval_c;
  logic [BPP-1:0]    vid_pval_c;
  logic [DATA_W-1:0] ram_rdata;

  // Address/write control: host only ever touches the RAM on phase 0
  always_comb begin
    accept_c    = (state == ST_IDLE) && host_req && !slot_phase && !host_ack && !reset;
    prot_c      = 32'(addr_q) < 32'(PROT_LIMIT);
    merged_c    = DATA_W'(pix_lane(LANE_W'(old_q), 32'(pix_q), BPP, PPW, 1'b1, LANE_W'(pval_q)));
    host_pval_c = BPP'(pix_lane(LANE_W'(ram_rdata), 32'(pix_q), BPP, PPW, 1'b0, '0));
    vid_pval_c  = BPP'(pix_lane(LANE_W'(ram_rdata), 32'(vpix_q), BPP, PPW, 1'b0, '0));
    ram_addr_c  = slot_phase ? vid_addr : ((state == ST_IDLE) ? host_addr : addr_q);
    ram_we_c    = 1'b0;
    ram_wdata_c = host_wdata;
    if (accept_c && (host_op_e'(host_op) == OP_BYTE_WR)) ram_we_c = 1'b1;
    if ((state == ST_RMW_WRITE) && !slot_phase && !prot_c && !reset) begin
      ram_we_c    = 1'b1;
      ram_wdata_c = merged_c;
    end
  end

  vram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_c),
    .addr  (ram_addr_c),
    .wdata (ram_wdata_c),
    .rdata (ram_rdata)
  );

  // Slot phase and video scanout pipeline
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_phase <= 1'b0;
      vid_rd_q   <= 1'b0;
      vid_valid  <= 1'b0;
      vid_pixel  <= '0;
      vpix_q     <= '0;
    end else begin
      slot_phase <= ~slot_phase;
      vid_rd_q   <= slot_phase;
      vid_valid  <= vid_rd_q;
      if (slot_phase) vpix_q <= vid_pix;
      if (vid_rd_q)   vid_pixel <= vid_pval_c;
    end
  end

  // Host FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      host_ack   <= 1'b0;
      host_rdata <= '0;
      op_q       <= OP_BYTE_RD;
      addr_q     <= '0;
      pix_q      <= '0;
      pval_q     <= '0;
      old_q      <= '0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept_c) begin
            op_q   <= host_op_e'(host_op);
            addr_q <= host_addr;
            pix_q  <= host_pix;
            pval_q <= host_wdata[DATA_W-1 -: BPP];
            state  <= (host_op_e'(host_op) == OP_PIX_WR) ? ST_RMW_READ : ST_WAIT_ACK;
          end
        end
        ST_RMW_READ: begin
          old_q <= ram_rdata;
          state <= ST_RMW_WRITE;
        end
        ST_RMW_WRITE: begin
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          host_ack   <= 1'b1;
          host_rdata <= (op_q == OP_PIX_RD) ? DATA_W'(LANE_W'(host_pval_c) << (DATA_W - BPP))
                                            : ram_rdata;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitmap_vram_arbiter.sv
// Directed bench for bitmap_vram_arbiter: default 4bpp instance plus a 2bpp instance.
module tb_bitmap_vram_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        h0_req, h0_pix, h0_ack, v0_pix, v0_valid, phase0;
  logic [1:0]  h0_op;
  logic [14:0] h0_addr, v0_addr;
  logic [7:0]  h0_wd, h0_rd;
  logic [3:0]  v0_pixel;

  logic        h1_req, h1_ack, v1_valid, phase1;
  logic [1:0]  h1_op, h1_pix, v1_pix, v1_pixel;
  logic [14:0] h1_addr, v1_addr;
  logic [7:0]  h1_wd, h1_rd;

  int n_checks = 0;
  int n_fail   = 0;
  int tb_cyc   = 0;
  bit vpix_chk = 1'b0;

  bitmap_vram_arbiter u_dut0 (
    .clk(clk), .reset(reset),
    .host_req(h0_req), .host_op(h0_op), .host_addr(h0_addr), .host_pix(h0_pix),
    .host_wdata(h0_wd), .host_ack(h0_ack), .host_rdata(h0_rd),
    .vid_addr(v0_addr), .vid_pix(v0_pix), .vid_pixel(v0_pixel), .vid_valid(v0_valid),
    .slot_phase(phase0)
  );

  bitmap_vram_arbiter #(.BPP(2)) u_dut1 (
    .clk(clk), .reset(reset),
    .host_req(h1_req), .host_op(h1_op), .host_addr(h1_addr), .host_pix(h1_pix),
    .host_wdata(h1_wd), .host_ack(h1_ack), .host_rdata(h1_rd),
    .vid_addr(v1_addr), .vid_pix(v1_pix), .vid_pixel(v1_pixel), .vid_valid(v1_valid),
    .slot_phase(phase1)
  );

  // Reference slot counter: phase of the current cycle is tb_cyc[0]
  always @(posedge clk or posedge reset) begin
    if (reset) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scanout runs continuously; valid must pulse on every phase-1 cycle regardless of host traffic
  always @(negedge clk) begin
    if (!reset) begin
      check("vid_valid", 32'(v0_valid), 32'((tb_cyc >= 3) && tb_cyc[0]));
      if (vpix_chk && v0_valid) check("vid_pixel", 32'(v0_pixel), 32'h5);
    end
  end

  task automatic wait_phase(input bit p);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (tb_cyc[0] == p) return;
    end
    check("wait_phase_timeout", 32'd1, 32'd0);
  endtask

  task automatic host_txn(input bit sel, input logic [1:0] op, input logic [14:0] addr,
                          input logic [1:0] pix, input logic [7:0] wd, input bit scramble,
                          output int lat, output logic [7:0] rd);
    lat = 0;
    rd  = 'x;
    if (sel) begin
      h1_op = op; h1_addr = addr; h1_pix = pix; h1_wd = wd; h1_req = 1'b1;
    end else begin
      h0_op = op; h0_addr = addr; h0_pix = pix[0]; h0_wd = wd; h0_req = 1'b1;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (scramble && i == 1) begin
        h0_addr = 15'h0000;
        h0_wd   = 8'h00;
      end
      if (sel ? h1_ack : h0_ack) begin
        lat = i;
        rd  = sel ? h1_rd : h0_rd;
        break;
      end
    end
    h0_req = 1'b0;
    h1_req = 1'b0;
  endtask

  int         lat;
  logic [7:0] rd;

  initial begin
    reset = 1'b1;
    h0_req = 1'b0; h0_op = 2'd0; h0_addr = '0; h0_pix = 1'b0; h0_wd = '0;
    h1_req = 1'b0; h1_op = 2'd0; h1_addr = '0; h1_pix = '0;   h1_wd = '0;
    v0_addr = 15'h5000; v0_pix = 1'b1;
    v1_addr = 15'h0000; v1_pix = 2'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_host_ack",   32'(h0_ack),   32'h0);
    check("rst_host_rdata", 32'(h0_rd),    32'h0);
    check("rst_vid_pixel",  32'(v0_pixel), 32'h0);
    check("rst_vid_valid",  32'(v0_valid), 32'h0);
    check("rst_slot_phase", 32'(phase0),   32'h0);

    // Byte write then byte read
    wait_phase(1'b0);
    host_txn(1'b0, 2'd1, 15'h5000, 2'd0, 8'hA5, 1'b0, lat, rd);
    check("bw_lat", 32'(lat), 32'd2);
    wait_phase(1'b0);
    host_txn(1'b0, 2'd0, 15'h5000, 2'd0, 8'h00, 1'b0, lat, rd);
    check("br_lat", 32'(lat), 32'd2);
    check("br_data", 32'(rd), 32'hA5);
    vpix_chk = 1'b1;

    // Pixel write pix0 <- 3 with request fields changed after accept
    wait_phase(1'b0);
    host_txn(1'b0, 2'd3, 15'h5000, 2'd0, 8'h3C, 1'b1, lat, rd);
    check("pw_lat", 32'(lat), 32'd4);
    wait_phase(1'b0);
    host_txn(1'b0, 2'd0, 15'h5000, 2'd0, 8'h00, 1'b0, lat, rd);
    check("pw_word", 32'(rd), 32'h35);
    wait_phase(1'b0);
    host_txn(1'b0, 2'd2, 15'h5000, 2'd1, 8'h00, 1'b0, lat, rd);
    check("pr1_lat", 32'(lat), 32'd2);
    check("pr1_data", 32'(rd), 32'h50);
    wait_phase(1'b0);
    host_txn(1'b0, 2'd2, 15'h5000, 2'd0, 8'h00, 1'b0, lat, rd);
    check("pr0_data", 32'(rd), 32'h30);

    // Protected region: pixel write acked but dropped, byte write lands
    wait_phase(1'b0);
    host_txn(1'b0, 2'd1, 15'h0FFF, 2'd0, 8'h77, 1'b0, lat, rd);
    wait_phase(1'b0);
    host_txn(1'b0, 2'd3, 15'h0FFF, 2'd1, 8'hF0, 1'b0, lat, rd);
    check("prot_pw_lat", 32'(lat), 32'd4);
    wait_phase(1'b0);
    host_txn(1'b0, 2'd0, 15'h0FFF, 2'd0, 8'h00, 1'b0, lat, rd);
    check("prot_unchanged", 32'(rd), 32'h77);
    wait_phase(1'b0);
    host_txn(1'b0, 2'd1, 15'h0FFF, 2'd0, 8'h12, 1'b0, lat, rd);
    wait_phase(1'b0);
    host_txn(1'b0, 2'd0, 15'h0FFF, 2'd0, 8'h00, 1'b0, lat, rd);
    check("prot_bw_lands", 32'(rd), 32'h12);

    // Request raised in a video slot waits one cycle
    wait_phase(1'b1);
    host_txn(1'b0, 2'd0, 15'h5000, 2'd0, 8'h00, 1'b0, lat, rd);
    check("ph1_lat", 32'(lat), 32'd3);
    check("ph1_data", 32'(rd), 32'h35);

    // Reset during RMW_READ aborts the pixel write
    wait_phase(1'b0);
    h0_op = 2'd3; h0_addr = 15'h5000; h0_pix = 1'b1; h0_wd = 8'hC0; h0_req = 1'b1;
    @(negedge clk);
    reset  = 1'b1;
    h0_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_ack",   32'(h0_ack),   32'h0);
    check("mid_rst_rdata", 32'(h0_rd),    32'h0);
    check("mid_rst_pixel", 32'(v0_pixel), 32'h0);
    check("mid_rst_valid", 32'(v0_valid), 32'h0);
    check("mid_rst_phase", 32'(phase0),   32'h0);
    host_txn(1'b0, 2'd0, 15'h5000, 2'd0, 8'h00, 1'b0, lat, rd);
    check("post_rst_lat", 32'(lat), 32'd2);
    check("post_rst_data", 32'(rd), 32'h35);

    // 2bpp instance: pixel 3 is the low lane
    wait_phase(1'b0);
    host_txn(1'b1, 2'd1, 15'h6000, 2'd0, 8'hFF, 1'b0, lat, rd);
    check("b2_bw_lat", 32'(lat), 32'd2);
    wait_phase(1'b0);
    host_txn(1'b1, 2'd3, 15'h6000, 2'd3, 8'h40, 1'b0, lat, rd);
    check("b2_pw_lat", 32'(lat), 32'd4);
    wait_phase(1'b0);
    host_txn(1'b1, 2'd0, 15'h6000, 2'd0, 8'h00, 1'b0, lat, rd);
    check("b2_word", 32'(rd), 32'hFD);
    wait_phase(1'b0);
    host_txn(1'b1, 2'd2, 15'h6000, 2'd3, 8'h00, 1'b0, lat, rd);
    check("b2_pix3", 32'(rd), 32'h40);

    @(negedge clk);
    check("phase_track", 32'(phase0), 32'(tb_cyc[0]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
